check_move_kick: RTL
====================

# check_move_kick

Parametrised successor to the game-logic move checker. It tests a requested move of the active piece against the occupied-cell field, one piece cell per clock, and stops at the first collision. For rotations it can retry the rotated piece at a sequence of horizontal kick offsets. It sits between the game FSM (which issues a request and waits for `done_o`) and the field store (which drives `field_i`).

## Interface
Parameters:
- `BLK_SIZE`, 4: piece bounding-box side; the piece has N = BLK_SIZE² cells.
- `ROW_CNT`, 22: field rows.
- `COL_CNT`, 12: field columns.
- `KICK_CNT`, 0: extra rotate attempts after the unkicked one; legal range 0..6.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `run_i`, in, 1: start pulse; sampled only when `busy_o`=0.
- `req_move_i`, in, move_t: requested move.
- `blk_x_i`, in, signed [$clog2(COL_CNT):0]: piece column origin.
- `blk_y_i`, in, signed [$clog2(ROW_CNT):0]: piece row origin.
- `blk_rot_i`, in, 2: current rotation index.
- `blk_data_i`, in, [3:0][BLK_SIZE-1:0][BLK_SIZE-1:0]: cell masks for the 4 rotations.
- `field_i`, in, [ROW_CNT-1:0][COL_CNT-1:0]: occupancy; the caller holds it stable while `busy_o`=1.
- `busy_o`, out, 1: check in progress.
- `done_o`, out, 1: one-cycle completion pulse.
- `can_move_o`, out, 1: result; valid from the `done_o` cycle until the next accepted `run_i`.
- `move_x_o`, out, signed [3:0]: applied x delta, including any kick.
- `move_y_o`, out, signed [1:0]: applied y delta.
- `kick_idx_o`, out, [2:0]: attempt index that succeeded; 0 if no kick was needed.

## Operation
- States: IDLE, SCAN, DONE.
- Capture on `run_i` in IDLE:
  - Latch the base delta: LEFT (-1,0), RIGHT (+1,0), DOWN (0,+1), ROTATE, APPEAR and other values (0,0).
  - Latch the mask: `blk_data_i[blk_rot_i+1]` for ROTATE (2-bit wrap, 3→0), `blk_data_i[blk_rot_i]` otherwise.
  - Latch `blk_x_i` and `blk_y_i`.
- Cell scan, row-major index c = 0..N-1, row = c / BLK_SIZE, col = c % BLK_SIZE.
  - Target column = x + col + dx + kick(a); target row = y + row + dy. Sign-extended arithmetic, one bit wider than the port.
- A cell collides if its mask bit is set AND any of these holds:
  - target row < 0, or target row ≥ ROW_CNT;
  - target column < 0, or target column ≥ COL_CNT;
  - the field bit at the target is set.
- Out-of-range targets must never index `field_i`.
- Kick offset for attempt a: 0 for a=0; +(a+1)/2 for odd a; −a/2 for even a (sequence 0, +1, −1, +2, −2, +3, −3).
- Kicks apply only to ROTATE. Other moves have a single attempt.
- On a collision: if ROTATE and a < KICK_CNT, go to a+1 and reset c to 0. Otherwise go to DONE with `can_move_o`=0.
- If c=N-1 is clear, go to DONE with `can_move_o`=1, `move_x_o` = dx + kick(a), and `kick_idx_o` = a.
- On failure, `move_x_o`/`move_y_o` report the base delta and `kick_idx_o`=0.
- DONE: assert `done_o` for one cycle, then return to IDLE.
- `run_i` while busy is ignored; no queueing.
- An empty mask (all zero) succeeds after N cycles.

## Timing
- Reset value 0 on all outputs; state IDLE; scan and attempt counters 0.
- Reset asserted mid-scan aborts the check; no `done_o` is produced.
- `run_i` sampled high at edge t: `busy_o`=1 from t+1; cell c of attempt 0 is evaluated in cycle t+1+c.
- Clean non-rotate check: `done_o` at t+N+1; `busy_o` falls at the same edge at which `done_o` rises.
- Collision at cell k of the final attempt: `done_o` at t+k+2 (early abort).
- Each failed attempt a costs k_a+1 cycles, with no idle gap between attempts.
- Worst case: (KICK_CNT+1)·N+1 cycles.
- A new `run_i` is accepted in the `done_o` cycle's successor (IDLE) at the earliest.

## Structure
- Shared game-logic package (defs): `move_t`, plus the kick-sequence function `kick_offset(a)`.
- Local to the block: state enum, counters, latched mask and deltas.
- One natural sub-module, `field_probe`: combinational. Inputs are the target row and column plus the field; outputs a collide flag, with bounds checked before indexing.

## Test plan
- Empty field, piece at (4,0), MOVE_DOWN, 4×4 I-piece horizontal → `can_move_o`=1, `move_y_o`=+1, `done_o` at t+17.
- Piece flush at column 0, MOVE_LEFT → `can_move_o`=0, early-abort `done_o` at t+k+2, where k is the first set cell with col=0.
- Piece at right wall, ROTATE with KICK_CNT=2, attempt 0 blocked, attempt 1 (+1) blocked by wall, attempt 2 (−1) clear → `can_move_o`=1, `move_x_o`=−1, `kick_idx_o`=2.
- Same setup with KICK_CNT=0 → `can_move_o`=0, `kick_idx_o`=0.
- Piece resting on the floor row ROW_CNT-1, MOVE_DOWN → `can_move_o`=0 via the upper-bound check, with no X on `field_i` indexing.
- `run_i` pulsed during SCAN → ignored, the original result stands. `rst_i` mid-scan → outputs 0 immediately, no `done_o` afterwards.

Source files
------------

// File: rtl/check_move_kick_pkg.sv
// Shared game-logic definitions: move requests and the rotation kick sequence.
package check_move_kick_pkg;

  typedef enum logic [2:0] {
    MOVE_NONE   = 3'd0,
    MOVE_LEFT   = 3'd1,
    MOVE_RIGHT  = 3'd2,
    MOVE_DOWN   = 3'd3,
    MOVE_ROTATE = 3'd4,
    MOVE_APPEAR = 3'd5
  } move_t;

  // Horizontal offset tried on attempt a: 0, +1, -1, +2, -2, +3, -3.
  function automatic logic signed [3:0] kick_offset(input logic [2:0] a);
    logic [3:0] a_w;
    a_w = {1'b0, a};
    if (a_w[0]) begin
      return $signed((a_w + 4'd1) >> 1);
    end
    return -$signed(a_w >> 1);
  endfunction

endpackage

// File: rtl/check_move_kick_probe.sv
// Combinational field probe: flags a target cell that lies outside the field
// or lands on an occupied cell. The field is only indexed once both
// coordinates are known to be in range.
module field_probe #(
  parameter int ROW_CNT = 22,
  parameter int COL_CNT = 12,
  parameter int RW      = 7,
  parameter int CW      = 6
) (
  input  logic signed [RW-1:0]              row_i,
  input  logic signed [CW-1:0]              col_i,
  input  logic [ROW_CNT-1:0][COL_CNT-1:0]   field_i,
  output logic                              collide_o
);

  localparam int RIW = $clog2(ROW_CNT);
  localparam int CIW = $clog2(COL_CNT);
  localparam logic signed [RW-1:0] ROW_LIM = RW'(ROW_CNT);
  localparam logic signed [CW-1:0] COL_LIM = CW'(COL_CNT);

  // Bounds first; the field lookup is reached only for in-range targets.
  always_comb begin
    collide_o = 1'b0;
    if (row_i[RW-1] || (row_i >= ROW_LIM) || col_i[CW-1] || (col_i >= COL_LIM)) begin
      collide_o = 1'b1;
    end else begin
      collide_o = field_i[row_i[RIW-1:0]][col_i[CIW-1:0]];
    end
  end

endmodule

// File: rtl/check_move_kick.sv
// Move checker with rotation kicks: scans the active piece one cell per
// clock against the field and stops at the first colliding cell.
module check_move_kick
  import check_move_kick_pkg::*;
#(
  parameter int BLK_SIZE = 4,
  parameter int ROW_CNT  = 22,
  parameter int COL_CNT  = 12,
  parameter int KICK_CNT = 0
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic                                              run_i,
  input  move_t                                             req_move_i,
  input  logic signed [$clog2(COL_CNT):0]                   blk_x_i,
  input  logic signed [$clog2(ROW_CNT):0]                   blk_y_i,
  input  logic [1:0]                                        blk_rot_i,
  input  logic [3:0][BLK_SIZE-1:0][BLK_SIZE-1:0]            blk_data_i,
  input  logic [ROW_CNT-1:0][COL_CNT-1:0]                   field_i,
  output logic                                              busy_o,
  output logic                                              done_o,
  output logic                                              can_move_o,
  output logic signed [3:0]                                 move_x_o,
  output logic signed [1:0]                                 move_y_o,
  output logic [2:0]                                        kick_idx_o
);

  localparam int N   = BLK_SIZE * BLK_SIZE;
  localparam int CIW = $clog2(N);
  localparam int XW  = $clog2(COL_CNT) + 1;
  localparam int YW  = $clog2(ROW_CNT) + 1;
  localparam int TXW = XW + 1;
  localparam int TYW = YW + 1;
  localparam logic [CIW-1:0] CELL_LAST = CIW'(N - 1);
  localparam logic [CIW-1:0] BLK_W     = CIW'(BLK_SIZE);
  localparam logic [2:0]     KICK_MAX  = 3'(KICK_CNT);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic                   vld_p0;
  logic [CIW-1:0]         cell_q;
  logic [2:0]             att_q;
  logic [N-1:0]           mask_q;
  logic signed [XW-1:0]   x_q;
  logic signed [YW-1:0]   y_q;
  logic signed [1:0]      dx_q, dy_q, dx_d, dy_d;
  logic                   is_rot_q;
  logic [1:0]             rot_next;
  logic                   accept;
  logic [CIW-1:0]         cell_row, cell_col;
  logic signed [3:0]      kick_w;
  logic signed [TXW-1:0]  tgt_x;
  logic signed [TYW-1:0]  tgt_y;
  logic                   probe_hit, hit, retry, last_cell;

  assign accept    = (state_q == S_IDLE) && !vld_p0 && run_i;
  assign rot_next  = blk_rot_i + 2'd1;
  assign cell_row  = cell_q / BLK_W;
  assign cell_col  = cell_q % BLK_W;
  assign kick_w    = kick_offset(att_q);
  assign tgt_x     = TXW'(x_q) + TXW'($signed({1'b0, cell_col})) + TXW'(dx_q) + TXW'(kick_w);
  assign tgt_y     = TYW'(y_q) + TYW'($signed({1'b0, cell_row})) + TYW'(dy_q);
  assign hit       = mask_q[cell_q] & probe_hit;
  assign retry     = is_rot_q && (att_q < KICK_MAX);
  assign last_cell = (cell_q == CELL_LAST);

  field_probe #(
    .ROW_CNT (ROW_CNT),
    .COL_CNT (COL_CNT),
    .RW      (TYW),
    .CW      (TXW)
  ) u_probe (
    .row_i     (tgt_y),
    .col_i     (tgt_x),
    .field_i   (field_i),
    .collide_o (probe_hit)
  );

  // Base delta of the requested move; rotate and appear only change the mask.
  always_comb begin
    dx_d = 2'sd0;
    dy_d = 2'sd0;
    case (req_move_i)
      MOVE_LEFT:  dx_d = -2'sd1;
      MOVE_RIGHT: dx_d = 2'sd1;
      MOVE_DOWN:  dy_d = 2'sd1;
      default:    ;
    endcase
  end

  // ---- p0: request capture (data registers carry no reset) ----
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mask_q   <= (req_move_i == MOVE_ROTATE) ? blk_data_i[rot_next] : blk_data_i[blk_rot_i];
      x_q      <= blk_x_i;
      y_q      <= blk_y_i;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      is_rot_q <= (req_move_i == MOVE_ROTATE);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: start after capture, leave the scan on a final hit or clean last cell.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (vld_p0) state_d = S_SCAN;
      S_SCAN: begin
        if (hit) begin
          if (!retry) state_d = S_DONE;
        end else if (last_cell) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- p1: scan counters and result registers ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0     <= 1'b0;
      cell_q     <= '0;
      att_q      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      can_move_o <= 1'b0;
      move_x_o   <= '0;
      move_y_o   <= '0;
      kick_idx_o <= '0;
    end else begin
      vld_p0 <= accept;
      done_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (vld_p0) begin
            busy_o     <= 1'b1;
            cell_q     <= '0;
            att_q      <= '0;
            can_move_o <= 1'b0;
          end
        end
        S_SCAN: begin
          if (hit) begin
            if (retry) begin
              att_q  <= att_q + 3'd1;
              cell_q <= '0;
            end else begin
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
              can_move_o <= 1'b0;
              move_x_o   <= 4'(dx_q);
              move_y_o   <= dy_q;
              kick_idx_o <= '0;
            end
          end else if (last_cell) begin
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            can_move_o <= 1'b1;
            move_x_o   <= 4'(dx_q) + kick_w;
            move_y_o   <= dy_q;
            kick_idx_o <= att_q;
          end else begin
            cell_q <= cell_q + CIW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
